// File: rtl/decode_pkg.sv
// Purpose: shared opcode constants, ECALL encoding and branch-wait state type for the decode stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package decode_pkg;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } br_state_t;

endpackage

// File: rtl/decode_operand_stage_imm_gen.sv
// Purpose: RISC-V immediate generator (I/S/B/U/J formats plus shift amounts), sign-extended to XLEN.
// Latency: purely combinational.
// Backpressure: none; output follows ir.
// Ports: ir - 32-bit instruction in; imm - XLEN-bit immediate out.
module imm_gen #(
  parameter int XLEN = 64
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);
  import decode_pkg::*;

  logic [31:0] raw;

  always_comb begin
    raw = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      STORE:      raw = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      BRANCH:     raw = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      LUI, AUIPC: raw = {ir[31:12], 12'b0};
      JAL:        raw = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      // Shifts (funct3 001/101) carry a zero-extended shamt; on 64-bit the
      // native OP-IMM shamt is 6 bits, the word forms stay at 5 bits.
      OP_IMM: begin
        if (ir[13:12] == 2'b01) begin
          if (XLEN == 64) raw = {26'b0, ir[25:20]};
          else            raw = {27'b0, ir[24:20]};
        end
      end
      OP_IMM_32: begin
        if (ir[13:12] == 2'b01) raw = {27'b0, ir[24:20]};
      end
      default: ;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/decode_operand_stage.sv
// Purpose: decode/operand-fetch stage: register file, immediates, priority forwarding, load-use and branch-wait control, DE->EXE register.
// Latency: 1 cycle decode to EXE outputs; forwarding/immediates combinational; write-back visible same cycle.
// Backpressure: MEM_STALL holds the EXE register; DE_STALL holds fetch/decode on MEM_STALL, load-use, or unresolved branch.
// Ports: CLK/RESET; DE_* decode instruction; FWD_* forwarding sources (index 0 youngest);
//        WB_* register write; BR_RESOLVE, MEM_STALL control in; DE_STALL and EXE_* pipeline register out.
module decode_operand_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NFWD  = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 DE_V,
  input  logic [31:0]          DE_IR,
  input  logic [XLEN-1:0]      DE_NPC,
  input  logic [NFWD-1:0]      FWD_V,
  input  logic [5*NFWD-1:0]    FWD_DRID,
  input  logic [XLEN*NFWD-1:0] FWD_DATA,
  input  logic [NFWD-1:0]      FWD_IS_LOAD,
  input  logic                 WB_LD_REG,
  input  logic [4:0]           WB_DRID,
  input  logic [XLEN-1:0]      WB_DATA,
  input  logic                 BR_RESOLVE,
  input  logic                 MEM_STALL,
  output logic                 DE_STALL,
  output logic                 EXE_V,
  output logic                 EXE_ECALL,
  output logic [31:0]          EXE_IR,
  output logic [XLEN-1:0]      EXE_NPC,
  output logic [XLEN-1:0]      EXE_ALU_ONE,
  output logic [XLEN-1:0]      EXE_ALU_TWO,
  output logic [XLEN-1:0]      EXE_RS2_DATA
);
  import decode_pkg::*;

  logic [6:0]      opc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rf1, rf2, op1, op2, imm, alu_one, alu_two;
  logic            ld1, ld2, uses1, uses2, load_use, issue, is_ctrl;
  br_state_t       state, state_nxt;

  assign opc = DE_IR[6:0];
  assign rs1 = DE_IR[19:15];
  assign rs2 = DE_IR[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (DE_IR),
    .imm (imm)
  );

  // Register file; x0 is never written so it always reads zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WB_LD_REG && WB_DRID != 5'd0) begin
      regs[WB_DRID] <= WB_DATA;
    end
  end

  // Write-through so a same-cycle write-back is seen by the reader.
  always_comb begin
    rf1 = regs[rs1];
    rf2 = regs[rs2];
    if (WB_LD_REG && WB_DRID == rs1) rf1 = WB_DATA;
    if (WB_LD_REG && WB_DRID == rs2) rf2 = WB_DATA;
  end

  // Forwarding: walk oldest to youngest so the lowest index wins.
  always_comb begin
    op1 = rf1;
    op2 = rf2;
    ld1 = 1'b0;
    ld2 = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (FWD_V[i] && FWD_DRID[5*i +: 5] == rs1) begin
        op1 = FWD_DATA[XLEN*i +: XLEN];
        ld1 = FWD_IS_LOAD[i];
      end
      if (FWD_V[i] && FWD_DRID[5*i +: 5] == rs2) begin
        op2 = FWD_DATA[XLEN*i +: XLEN];
        ld2 = FWD_IS_LOAD[i];
      end
    end
    if (rs1 == 5'd0) begin
      op1 = '0;
      ld1 = 1'b0;
    end
    if (rs2 == 5'd0) begin
      op2 = '0;
      ld2 = 1'b0;
    end
  end

  // Which source registers the instruction actually consumes.
  always_comb begin
    uses1 = 1'b0;
    uses2 = 1'b0;
    case (opc)
      OP, OP_32, STORE, BRANCH: begin
        uses1 = 1'b1;
        uses2 = 1'b1;
      end
      OP_IMM, OP_IMM_32, LOAD, JALR: uses1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = DE_V && ((uses1 && ld1) || (uses2 && ld2));
  assign is_ctrl  = (opc == BRANCH) || (opc == JAL) || (opc == JALR);
  assign issue    = !MEM_STALL && (state == IDLE) && DE_V && !load_use;

  always_comb begin
    alu_one = op1;
    if (opc == LUI)                        alu_one = '0;
    else if (opc == AUIPC || opc == JAL)   alu_one = DE_NPC - XLEN'(4);
    alu_two = imm;
    if (opc == OP || opc == OP_32)         alu_two = op2;
  end

  // Branch-wait FSM
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue && is_ctrl) state_nxt = BR_WAIT;
      BR_WAIT: if (BR_RESOLVE)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign DE_STALL = MEM_STALL || load_use || (state == BR_WAIT && !BR_RESOLVE);

  // DE->EXE pipeline register; a bubble only clears valid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      EXE_V        <= 1'b0;
      EXE_ECALL    <= 1'b0;
      EXE_IR       <= '0;
      EXE_NPC      <= '0;
      EXE_ALU_ONE  <= '0;
      EXE_ALU_TWO  <= '0;
      EXE_RS2_DATA <= '0;
    end else if (MEM_STALL) begin
      EXE_V <= EXE_V;
    end else if (!issue) begin
      EXE_V <= 1'b0;
    end else begin
      EXE_V        <= 1'b1;
      EXE_ECALL    <= (DE_IR == ECALL);
      EXE_IR       <= DE_IR;
      EXE_NPC      <= DE_NPC;
      EXE_ALU_ONE  <= alu_one;
      EXE_ALU_TWO  <= alu_two;
      EXE_RS2_DATA <= op2;
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Purpose: self-checking bench for decode_operand_stage (vector table plus multi-cycle sequences).
// Latency: inputs driven on negedge, combinational outputs checked before posedge, EXE outputs #1 after posedge.
// Backpressure: exercises MEM_STALL hold, load-use bubble and branch-wait bubbles.
module tb_decode_operand_stage;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          DE_V;
  logic [31:0]   DE_IR;
  logic [63:0]   DE_NPC;
  logic [2:0]    FWD_V;
  logic [14:0]   FWD_DRID;
  logic [191:0]  FWD_DATA;
  logic [2:0]    FWD_IS_LOAD;
  logic          WB_LD_REG;
  logic [4:0]    WB_DRID;
  logic [63:0]   WB_DATA;
  logic          BR_RESOLVE;
  logic          MEM_STALL;
  logic          DE_STALL;
  logic          EXE_V;
  logic          EXE_ECALL;
  logic [31:0]   EXE_IR;
  logic [63:0]   EXE_NPC;
  logic [63:0]   EXE_ALU_ONE;
  logic [63:0]   EXE_ALU_TWO;
  logic [63:0]   EXE_RS2_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  decode_operand_stage #(.XLEN(64), .NREGS(32), .NFWD(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DE_V         (DE_V),
    .DE_IR        (DE_IR),
    .DE_NPC       (DE_NPC),
    .FWD_V        (FWD_V),
    .FWD_DRID     (FWD_DRID),
    .FWD_DATA     (FWD_DATA),
    .FWD_IS_LOAD  (FWD_IS_LOAD),
    .WB_LD_REG    (WB_LD_REG),
    .WB_DRID      (WB_DRID),
    .WB_DATA      (WB_DATA),
    .BR_RESOLVE   (BR_RESOLVE),
    .MEM_STALL    (MEM_STALL),
    .DE_STALL     (DE_STALL),
    .EXE_V        (EXE_V),
    .EXE_ECALL    (EXE_ECALL),
    .EXE_IR       (EXE_IR),
    .EXE_NPC      (EXE_NPC),
    .EXE_ALU_ONE  (EXE_ALU_ONE),
    .EXE_ALU_TWO  (EXE_ALU_TWO),
    .EXE_RS2_DATA (EXE_RS2_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]  ir;
    logic [63:0]  npc;
    logic         dv;
    logic [2:0]   fv;
    logic [14:0]  drid;
    logic [191:0] data;
    logic [2:0]   ld;
    logic         e_stall;
    logic         e_v;
    logic         chk;
    logic [63:0]  e_a1;
    logic [63:0]  e_a2;
    logic [63:0]  e_rs2;
    logic         e_ecall;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mkv(input logic [31:0] ir, input logic [63:0] npc, input logic dv,
                               input logic [2:0] fv, input logic [14:0] drid, input logic [191:0] data,
                               input logic [2:0] ld, input logic e_stall, input logic e_v, input logic chk,
                               input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] rs2,
                               input logic ecall);
    vec_t v;
    v.ir = ir; v.npc = npc; v.dv = dv; v.fv = fv; v.drid = drid; v.data = data; v.ld = ld;
    v.e_stall = e_stall; v.e_v = e_v; v.chk = chk;
    v.e_a1 = a1; v.e_a2 = a2; v.e_rs2 = rs2; v.e_ecall = ecall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    DE_V = 1'b0; DE_IR = 32'h0; DE_NPC = 64'h1004;
    FWD_V = 3'b0; FWD_DRID = 15'h0; FWD_DATA = 192'h0; FWD_IS_LOAD = 3'b0;
    WB_LD_REG = 1'b0; WB_DRID = 5'd0; WB_DATA = 64'h0;
    BR_RESOLVE = 1'b0; MEM_STALL = 1'b0;
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ir, npc, dv, fv, drid{2,1,0}, data{2,1,0}, ld, stall, v, chk, alu1, alu2, rs2, ecall
    vecs[0]  = mkv(32'h006280B3, 64'h1004, 1, 3'b011, {5'd0, 5'd5, 5'd5}, {64'h0, 64'hBB, 64'hAA}, 3'b000,
                   0, 1, 1, 64'hAA, 64'h0, 64'h0, 0);                              // ADD x1,x5,x6 priority
    vecs[1]  = mkv(32'hFFF00093, 64'h1004, 1, 3'b001, {5'd0, 5'd0, 5'd0}, {64'h0, 64'h0, 64'hFF}, 3'b000,
                   0, 1, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);             // ADDI x1,x0,-1
    vecs[2]  = mkv(32'h12345137, 64'h1004, 1, 3'b000, 15'h0, 192'h0, 3'b000,
                   0, 1, 1, 64'h0, 64'h0000_0000_1234_5000, 64'h0, 0);             // LUI
    vecs[3]  = mkv(32'h80000197, 64'h2004, 1, 3'b000, 15'h0, 192'h0, 3'b000,
                   0, 1, 1, 64'h2000, 64'hFFFF_FFFF_8000_0000, 64'h0, 0);          // AUIPC
    vecs[4]  = mkv(32'hFE62AE23, 64'h1004, 1, 3'b011, {5'd0, 5'd5, 5'd6}, {64'h0, 64'h55, 64'h66}, 3'b000,
                   0, 1, 1, 64'h55, 64'hFFFF_FFFF_FFFF_FFFC, 64'h66, 0);           // SW x6,-4(x5)
    vecs[5]  = mkv(32'h40315093, 64'h1004, 1, 3'b000, 15'h0, 192'h0, 3'b000,
                   0, 1, 1, 64'h0, 64'h3, 64'h0, 0);                               // SRAI x1,x2,3
    vecs[6]  = mkv(32'h0231109B, 64'h1004, 1, 3'b000, 15'h0, 192'h0, 3'b000,
                   0, 1, 1, 64'h0, 64'h3, 64'h0, 0);                               // word shift, 5-bit shamt
    vecs[7]  = mkv(32'h003100BB, 64'h1004, 1, 3'b110, {5'd3, 5'd2, 5'd2}, {64'h33, 64'h22, 64'hEE}, 3'b000,
                   0, 1, 1, 64'h22, 64'h33, 64'h33, 0);                            // ADDW x1,x2,x3
    vecs[8]  = mkv(32'h00000073, 64'h1004, 1, 3'b000, 15'h0, 192'h0, 3'b000,
                   0, 1, 1, 64'h0, 64'h0, 64'h0, 1);                               // ECALL
    vecs[9]  = mkv(32'h00510093, 64'h1004, 1, 3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 64'h0, 64'h77}, 3'b001,
                   0, 1, 1, 64'h0, 64'h5, 64'h77, 0);                              // ADDI: rs2 load not a hazard
    vecs[10] = mkv(32'h006280B3, 64'h1004, 0, 3'b000, 15'h0, 192'h0, 3'b000,
                   0, 0, 0, 64'h0, 64'h0, 64'h0, 0);                               // DE_V=0 bubble

    // Reset
    idle_inputs();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 chk("reset_de_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("reset_exe_v", 64'(EXE_V), 64'h0);
    chk("reset_exe_ir", 64'(EXE_IR), 64'h0);
    chk("reset_alu_one", EXE_ALU_ONE, 64'h0);
    chk("reset_alu_two", EXE_ALU_TWO, 64'h0);
    chk("reset_rs2", EXE_RS2_DATA, 64'h0);
    chk("reset_ecall", 64'(EXE_ECALL), 64'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // Table
    for (int k = 0; k < NV; k++) begin
      @(negedge CLK);
      idle_inputs();
      DE_IR = vecs[k].ir; DE_NPC = vecs[k].npc; DE_V = vecs[k].dv;
      FWD_V = vecs[k].fv; FWD_DRID = vecs[k].drid; FWD_DATA = vecs[k].data; FWD_IS_LOAD = vecs[k].ld;
      #1 chk($sformatf("v%0d_de_stall", k), 64'(DE_STALL), 64'(vecs[k].e_stall));
      clk_edge();
      chk($sformatf("v%0d_exe_v", k), 64'(EXE_V), 64'(vecs[k].e_v));
      if (vecs[k].chk) begin
        chk($sformatf("v%0d_exe_ir", k), 64'(EXE_IR), 64'(vecs[k].ir));
        chk($sformatf("v%0d_exe_npc", k), EXE_NPC, vecs[k].npc);
        chk($sformatf("v%0d_alu_one", k), EXE_ALU_ONE, vecs[k].e_a1);
        chk($sformatf("v%0d_alu_two", k), EXE_ALU_TWO, vecs[k].e_a2);
        chk($sformatf("v%0d_rs2", k), EXE_RS2_DATA, vecs[k].e_rs2);
        chk($sformatf("v%0d_ecall", k), 64'(EXE_ECALL), 64'(vecs[k].e_ecall));
      end
    end

    // Load-use: ADD x4,x3,x2 with a pending load to x3
    @(negedge CLK);
    idle_inputs();
    DE_V = 1'b1; DE_IR = 32'h00218233;
    FWD_V = 3'b001; FWD_DRID = {5'd0, 5'd0, 5'd3}; FWD_DATA = {64'h0, 64'h0, 64'h99}; FWD_IS_LOAD = 3'b001;
    #1 chk("lu_stall", 64'(DE_STALL), 64'h1);
    clk_edge();
    chk("lu_bubble", 64'(EXE_V), 64'h0);
    @(negedge CLK);
    FWD_IS_LOAD = 3'b000;
    #1 chk("lu_release_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("lu_issue_v", 64'(EXE_V), 64'h1);
    chk("lu_issue_alu_one", EXE_ALU_ONE, 64'h99);

    // MEM_STALL hold
    @(negedge CLK);
    idle_inputs();
    DE_V = 1'b1; DE_IR = 32'h006280B3;
    clk_edge();
    chk("ms_first_ir", 64'(EXE_IR), 64'h006280B3);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      MEM_STALL = 1'b1; DE_IR = 32'h00510093;
      #1 chk($sformatf("ms_stall_%0d", k), 64'(DE_STALL), 64'h1);
      clk_edge();
      chk($sformatf("ms_hold_ir_%0d", k), 64'(EXE_IR), 64'h006280B3);
      chk($sformatf("ms_hold_v_%0d", k), 64'(EXE_V), 64'h1);
      chk($sformatf("ms_hold_alu_two_%0d", k), EXE_ALU_TWO, 64'h0);
    end
    @(negedge CLK);
    MEM_STALL = 1'b0;
    #1 chk("ms_release_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("ms_release_ir", 64'(EXE_IR), 64'h00510093);
    chk("ms_release_alu_two", EXE_ALU_TWO, 64'h5);

    // Branch wait: BEQ x1,x2,+8 then resolve three cycles later
    @(negedge CLK);
    idle_inputs();
    DE_V = 1'b1; DE_IR = 32'h00208463;
    #1 chk("br_issue_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("br_exe_v", 64'(EXE_V), 64'h1);
    chk("br_alu_two", EXE_ALU_TWO, 64'h8);
    @(negedge CLK);
    DE_IR = 32'h00510093;
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("br_wait_stall_%0d", k), 64'(DE_STALL), 64'h1);
      clk_edge();
      chk($sformatf("br_wait_bubble_%0d", k), 64'(EXE_V), 64'h0);
      @(negedge CLK);
    end
    BR_RESOLVE = 1'b1;
    #1 chk("br_resolve_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("br_resolve_bubble", 64'(EXE_V), 64'h0);
    @(negedge CLK);
    BR_RESOLVE = 1'b0;
    #1 chk("br_target_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("br_target_v", 64'(EXE_V), 64'h1);
    chk("br_target_ir", 64'(EXE_IR), 64'h00510093);

    // Write-through, then reset while in branch wait
    @(negedge CLK);
    idle_inputs();
    DE_V = 1'b1; DE_IR = 32'h00038433;
    WB_LD_REG = 1'b1; WB_DRID = 5'd7; WB_DATA = 64'h1234;
    clk_edge();
    chk("wt_alu_one", EXE_ALU_ONE, 64'h1234);
    @(negedge CLK);
    WB_LD_REG = 1'b0; WB_DATA = 64'h0;
    clk_edge();
    chk("rf_alu_one", EXE_ALU_ONE, 64'h1234);
    @(negedge CLK);
    DE_IR = 32'h0000006F; DE_NPC = 64'h3008;
    clk_edge();
    chk("jal_v", 64'(EXE_V), 64'h1);
    chk("jal_alu_one", EXE_ALU_ONE, 64'h3004);
    @(negedge CLK);
    DE_IR = 32'h00038433; DE_NPC = 64'h1004;
    #1 chk("jal_wait_stall", 64'(DE_STALL), 64'h1);
    RESET = 1'b1;
    clk_edge();
    chk("rst_bw_exe_v", 64'(EXE_V), 64'h0);
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("rst_bw_idle_stall", 64'(DE_STALL), 64'h0);
    clk_edge();
    chk("rst_bw_issue_v", 64'(EXE_V), 64'h1);
    chk("rst_x7_cleared", EXE_ALU_ONE, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_operand_stage.md
# decode_operand_stage

Parametrised decode/operand-fetch stage of the RISC-V pipeline, successor to the fixed 64-bit decode stage. Holds the integer register file, generates immediates, selects operands through an N-source priority forwarding network, detects load-use hazards, runs a branch-wait state machine, and drives the DE→EXE pipeline register with hold and bubble control. It sits between fetch (DE_*) and execute (EXE_*).

## Interface
- XLEN, 64, datapath width (32 or 64)
- NREGS, 32, architectural registers; x0 reads zero and ignores writes
- NFWD, 3, forwarding sources; index 0 is youngest and has highest priority
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- DE_V  in  1  decode instruction valid
- DE_IR  in  32  decode instruction
- DE_NPC  in  XLEN  PC+4 of the decode instruction
- FWD_V  in  NFWD  forwarding source valid and writes a register
- FWD_DRID  in  5*NFWD  destination register of each source
- FWD_DATA  in  XLEN*NFWD  result of each source
- FWD_IS_LOAD  in  NFWD  source is a load with data not yet available
- WB_LD_REG  in  1  register file write enable
- WB_DRID  in  5  write-back destination
- WB_DATA  in  XLEN  write-back data
- BR_RESOLVE  in  1  branch or jump in EXE resolved; fetch redirected
- MEM_STALL  in  1  downstream stall; hold the EXE register
- DE_STALL  out  1  hold fetch and decode
- EXE_V, EXE_ECALL  out  1  valid and ECALL (DE_IR == 32'h00000073)
- EXE_IR  out  32
- EXE_NPC  out  XLEN
- EXE_ALU_ONE, EXE_ALU_TWO, EXE_RS2_DATA  out  XLEN  ALU operands and store data

## Operation
- Register file write on the CLK edge when WB_LD_REG=1 and WB_DRID≠0. A same-cycle read of WB_DRID returns WB_DATA (write-through).
- Per rs1/rs2: take the lowest-index source i with FWD_V[i], FWD_DRID[i]==rs and rs≠0. If none matches, use the register file value. A source index with rs=0 always yields 0.
- Load-use: the winning source has FWD_IS_LOAD=1 and the instruction reads that rs (R-type, store, branch: rs1+rs2; I-type, load, JALR: rs1 only).
- Immediates: I, S, B, U, J formats, sign-extended to XLEN. The shamt field is IR[25:20] for OP-IMM on XLEN=64, and IR[24:20] for OP-IMM-32 or XLEN=32.
- ALU_ONE: 0 for LUI; DE_NPC−4 for AUIPC and JAL; otherwise forwarded rs1.
- ALU_TWO: forwarded rs2 for OP (0110011) and OP-32 (0111011); otherwise the immediate.
- RS2_DATA: always forwarded rs2.
- FSM states: IDLE and BR_WAIT.
  - IDLE→BR_WAIT when a valid branch, JAL or JALR is latched into EXE.
  - BR_WAIT→IDLE on BR_RESOLVE, regardless of MEM_STALL.
- EXE register update, highest priority first:
  1. RESET: all EXE_* outputs 0.
  2. MEM_STALL: hold all EXE_* outputs.
  3. BR_WAIT, load-use, or DE_V=0: EXE_V←0 (bubble); other fields don't-care.
  4. Otherwise latch all fields with EXE_V←1.
- DE_STALL = MEM_STALL | load_use | (state==BR_WAIT & !BR_RESOLVE).

## Timing
- Decode to EXE outputs: 1 cycle.
- Forwarding and immediate paths are combinational within the DE cycle.
- Write-back to a dependent read: 0 cycles (write-through).
- Load-use: exactly one bubble per cycle while FWD_IS_LOAD matches; the instruction issues on the first cycle without a match.
- Branch: bubbles from the cycle after the branch enters EXE through the BR_RESOLVE cycle inclusive. DE_STALL drops in the BR_RESOLVE cycle so fetch loads the target, and the target decodes in IDLE on the next cycle.
- Reset values:
  - state IDLE
  - all registers 0
  - all EXE_* outputs 0
  - DE_STALL follows its equation (MEM_STALL and load_use may still assert it)
- Reset in BR_WAIT returns to IDLE with no pending bubble.

## Structure
- Package decode_pkg holds:
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, OP_32, OP_IMM_32, SYSTEM)
  - the br_state_t enum {IDLE, BR_WAIT}
  - the ECALL encoding
- One sub-module, imm_gen (parameter XLEN), is purely combinational: DE_IR in, immediate out.
- The register file and forwarding network stay inline.

## Test plan
- Forward priority: FWD_V=3'b011, both DRID=5, DATA0=0xAA, DATA1=0xBB, ADD x1,x5,x6 → EXE_ALU_ONE=0xAA.
- x0: FWD_V[0]=1, DRID0=0, DATA0=0xFF, ADDI x1,x0,-1 → ALU_ONE=0, ALU_TWO=0xFFFF_FFFF_FFFF_FFFF.
- Load-use: FWD_IS_LOAD[0]=1, DRID0=3, ADD x4,x3,x2 → one cycle with DE_STALL=1 and EXE_V=0; the next cycle with IS_LOAD cleared gives EXE_V=1.
- Branch wait: valid BEQ latched; 3 cycles later BR_RESOLVE=1 → bubbles through the resolve cycle, DE_STALL low in the resolve cycle, next instruction gets EXE_V=1.
- MEM_STALL: hold for 2 cycles with a new DE_IR presented → EXE_* unchanged; DE_IR latched on release.
- Write-through and reset: WB writes x7=0x1234 while decoding ADD x8,x7,x0 → ALU_ONE=0x1234. RESET asserted in BR_WAIT → next cycle IDLE, EXE_V=0, x7 reads 0.
